// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port (I/D) main-memory arbiter.
// Owner and priority encodings double as indices into the per-side arrays.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// BUSY-cycle counter: flags the first BUSY cycle and the TIMEOUT-th BUSY cycle.
// The count clears whenever the arbiter is not in BUSY.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic busy,
    output logic first_cycle,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = '0;
        if (busy) begin
            count_next = (count_reg == CNT_W'(TIMEOUT)) ? count_reg : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign first_cycle = busy && (count_reg == '0);
    assign expired     = busy && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between an instruction
// cache (read-only) and a data cache; IDLE -> BUSY -> DONE per access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [DATA_W-1:0] i_mem_readdata,
    output logic              i_mem_busywait,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_writedata,
    output logic [DATA_W-1:0] d_mem_readdata,
    output logic              d_mem_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    arb_state_t        state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              prio_reg, prio_next;
    logic              op_write_reg, op_write_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              mem_read_reg, mem_write_reg;
    logic              timeout_reg;
    logic              grant_side;
    logic              capture;
    logic              timeout_set;
    logic              in_busy;
    logic              first_cycle;
    logic              expired;

    // Per-side vectors, indexed by the owner encoding (0 = D, 1 = I).
    logic [1:0]        req;
    logic [1:0]        busywait;
    logic [DATA_W-1:0] rdata [2];

    assign req[OWNER_D] = d_mem_read | d_mem_write;
    assign req[OWNER_I] = i_mem_read;
    assign in_busy      = (state_reg == ST_BUSY);

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .busy       (in_busy),
        .first_cycle(first_cycle),
        .expired    (expired)
    );

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        prio_next     = prio_reg;
        op_write_next = op_write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        grant_side    = OWNER_D;
        capture       = 1'b0;
        timeout_set   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    grant_side = (&req) ? prio_reg : req[OWNER_I];
                    owner_next = grant_side;
                    prio_next  = ~prio_reg;
                    state_next = ST_BUSY;
                    if (grant_side == OWNER_I) begin
                        addr_next     = i_mem_address;
                        op_write_next = 1'b0;
                    end else begin
                        addr_next     = d_mem_address;
                        wdata_next    = d_mem_writedata;
                        op_write_next = d_mem_write;
                    end
                end
            end
            ST_BUSY: begin
                // A genuine completion wins over a watchdog expiry in the same cycle.
                if (!first_cycle && !mem_busywait) begin
                    capture    = ~op_write_reg;
                    state_next = ST_DONE;
                end else if (expired) begin
                    timeout_set = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWNER_D;
            prio_reg      <= OWNER_D;
            op_write_reg  <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            prio_reg      <= prio_next;
            op_write_reg  <= op_write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            mem_read_reg  <= (state_next == ST_BUSY) && !op_write_next;
            mem_write_reg <= (state_next == ST_BUSY) && op_write_next;
            timeout_reg   <= timeout_reg | timeout_set;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        logic [DATA_W-1:0] rdata_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                rdata_reg <= '0;
            end else if (capture && (owner_reg == 1'(gi))) begin
                rdata_reg <= mem_readdata;
            end
        end

        assign rdata[gi]    = rdata_reg;
        assign busywait[gi] = req[gi] && !((state_reg == ST_DONE) && (owner_reg == 1'(gi)));
    end

    assign i_mem_readdata = rdata[OWNER_I];
    assign d_mem_readdata = rdata[OWNER_D];
    assign i_mem_busywait = busywait[OWNER_I];
    assign d_mem_busywait = busywait[OWNER_D];
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign mem_address    = addr_reg;
    assign mem_writedata  = wdata_reg;
    assign timeout_err    = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level
// model: grant order, access timing, strobes, readdata and watchdog behaviour.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_address;
    logic [DW-1:0] i_mem_readdata;
    logic          i_mem_busywait;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [AW-1:0] d_mem_address;
    logic [DW-1:0] d_mem_writedata;
    logic [DW-1:0] d_mem_readdata;
    logic          d_mem_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;
    logic          timeout_err;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_mem_read     (i_mem_read),
        .i_mem_address  (i_mem_address),
        .i_mem_readdata (i_mem_readdata),
        .i_mem_busywait (i_mem_busywait),
        .d_mem_read     (d_mem_read),
        .d_mem_write    (d_mem_write),
        .d_mem_address  (d_mem_address),
        .d_mem_writedata(d_mem_writedata),
        .d_mem_readdata (d_mem_readdata),
        .d_mem_busywait (d_mem_busywait),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_busywait   (mem_busywait),
        .timeout_err    (timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Bench-side main memory: busy for mem_n strobe cycles, ready on the next.
    logic [DW-1:0] mem_arr   [64];
    logic [DW-1:0] model_mem [64];
    int            mem_n     = 3;
    bit            mem_stall = 1'b0;
    int            mem_cyc   = 0;

    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            mem_cyc++;
            if (mem_stall || mem_cyc <= mem_n) begin
                mem_busywait = 1'b1;
            end else begin
                mem_busywait = 1'b0;
                if (mem_write) mem_arr[mem_address] = mem_writedata;
            end
            mem_readdata = mem_read ? mem_arr[mem_address] : DW'($urandom);
        end else begin
            mem_cyc      = 0;
            mem_busywait = 1'b0;
            mem_readdata = DW'($urandom);
        end
    end

    // Transaction-level model state: next-priority side and expected readdata (0 = D, 1 = I).
    bit            m_prio;
    logic [DW-1:0] m_rdata [2];

    task automatic model_reset();
        m_prio     = 1'b0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    task automatic do_trial(input bit i_rq, input bit d_rd, input bit d_wr,
                            input logic [AW-1:0] ia, input logic [AW-1:0] da,
                            input logic [DW-1:0] wd, input int n);
        int            order[$];
        bit            pend   [2];
        int            exp_t  [2];
        int            got_t  [2];
        int            rec_len[2];
        logic [AW-1:0] rec_addr[2];
        bit            rec_wr [2];
        logic [DW-1:0] rec_wd [2];
        int            nrec;
        bit            prev_strobe;
        bit            strobe;
        int            s;

        pend[0] = d_rd | d_wr;
        pend[1] = i_rq;
        if (pend[0] && pend[1]) begin
            order.push_back(int'(m_prio));
            order.push_back(int'(!m_prio));
        end else if (pend[0]) begin
            order.push_back(0);
        end else if (pend[1]) begin
            order.push_back(1);
        end
        // Each access occupies IDLE + (n+1) BUSY + DONE cycles back to back.
        for (int k = 0; k < order.size(); k++) begin
            m_prio = !m_prio;
            s = order[k];
            exp_t[s] = (k + 1) * (n + 3) - 1;
            if (s == 1) m_rdata[1] = model_mem[ia];
            else if (d_wr) model_mem[da] = wd;
            else m_rdata[0] = model_mem[da];
        end

        @(negedge clock);
        mem_n           = n;
        i_mem_read      = i_rq;
        i_mem_address   = ia;
        d_mem_read      = d_rd;
        d_mem_write     = d_wr;
        d_mem_address   = da;
        d_mem_writedata = wd;
        $display("txn: i=%0b(a=%0h) d_rd=%0b d_wr=%0b(a=%0h wd=%0h) mem_busy=%0d",
                 i_rq, ia, d_rd, d_wr, da, wd, n);

        got_t[0] = -1;
        got_t[1] = -1;
        rec_len[0] = 0;
        rec_len[1] = 0;
        nrec = 0;
        prev_strobe = 1'b0;
        for (int t = 1; t <= 2 * (n + 3) + 4; t++) begin
            @(negedge clock);
            strobe = mem_read | mem_write;
            if (strobe && !prev_strobe) begin
                if (nrec < 2) begin
                    rec_addr[nrec] = mem_address;
                    rec_wr[nrec]   = mem_write;
                    rec_wd[nrec]   = mem_writedata;
                end
                nrec++;
            end
            if (strobe && nrec >= 1 && nrec <= 2) rec_len[nrec-1]++;
            prev_strobe = strobe;
            if (pend[1] && got_t[1] < 0 && !i_mem_busywait) begin
                got_t[1] = t;
                check_eq("i_readdata_at_done", i_mem_readdata, m_rdata[1]);
                i_mem_read = 1'b0;
            end
            if (pend[0] && got_t[0] < 0 && !d_mem_busywait) begin
                got_t[0] = t;
                check_eq("d_readdata_at_done", d_mem_readdata, m_rdata[0]);
                d_mem_read  = 1'b0;
                d_mem_write = 1'b0;
            end
        end
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;

        check_eq("access_count", nrec, order.size());
        for (int k = 0; k < order.size() && k < nrec; k++) begin
            s = order[k];
            check_eq("grant_addr", rec_addr[k], (s == 1) ? ia : da);
            check_eq("grant_is_write", rec_wr[k], (s == 1) ? 1'b0 : d_wr);
            check_eq("strobe_cycles", rec_len[k], n + 1);
            if (s == 0 && d_wr) check_eq("writedata", rec_wd[k], wd);
        end
        for (int x = 0; x < 2; x++) begin
            if (pend[x]) check_eq(x ? "i_latency" : "d_latency", got_t[x], exp_t[x]);
        end
        check_eq("i_readdata_hold", i_mem_readdata, m_rdata[1]);
        check_eq("d_readdata_hold", d_mem_readdata, m_rdata[0]);
    endtask

    initial begin
        int  got;
        bit  irq;
        int  dsel;

        reset = 1'b1;
        i_mem_read = 1'b0;
        i_mem_address = '0;
        d_mem_read = 1'b0;
        d_mem_write = 1'b0;
        d_mem_address = '0;
        d_mem_writedata = '0;
        mem_busywait = 1'b0;
        mem_readdata = '0;
        for (int a = 0; a < 64; a++) begin
            mem_arr[a]   = DW'($urandom);
            model_mem[a] = mem_arr[a];
        end
        mem_arr[5]   = 32'hDEADBEEF;
        model_mem[5] = 32'hDEADBEEF;
        model_reset();

        // Reset state, and busywait following a pending request while in reset.
        repeat (3) @(negedge clock);
        i_mem_read = 1'b1;
        #1;
        check_eq("busywait_in_reset", i_mem_busywait, 1'b1);
        i_mem_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_mem_address", mem_address, '0);
        check_eq("rst_mem_writedata", mem_writedata, '0);
        check_eq("rst_i_readdata", i_mem_readdata, '0);
        check_eq("rst_d_readdata", d_mem_readdata, '0);
        check_eq("rst_timeout_err", timeout_err, 1'b0);
        check_eq("rst_busywaits", {i_mem_busywait, d_mem_busywait}, 2'b00);

        // Simultaneous I read and D write after reset: D first; write leaves d readdata alone.
        do_trial(1'b1, 1'b0, 1'b1, 6'h10, 6'h3A, 32'h01234567, 2);
        // Continuous contention: D, I, D, I.
        do_trial(1'b1, 1'b1, 1'b0, 6'h3A, 6'h21, 32'h0, 3);
        do_trial(1'b1, 1'b1, 1'b1, 6'h07, 6'h08, 32'hCAFEF00D, 1);
        // I-only read of 0x05 with 5 busy cycles.
        do_trial(1'b1, 1'b0, 1'b0, 6'h05, 6'h00, 32'h0, 5);

        for (int r = 0; r < 30; r++) begin
            irq  = 1'($urandom_range(0, 1));
            dsel = $urandom_range(0, 3);
            if (!irq && dsel == 0) irq = 1'b1;
            do_trial(irq, dsel[0], dsel[1], AW'($urandom), AW'($urandom), DW'($urandom),
                     $urandom_range(1, 5));
        end

        // Watchdog: memory never ready, access forced to DONE after TO BUSY cycles.
        @(negedge clock);
        mem_stall = 1'b1;
        i_mem_read = 1'b1;
        i_mem_address = 6'h2C;
        m_prio = !m_prio;
        $display("txn: i read a=2c with stalled memory");
        got = -1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clock);
            if (t == TO) check_eq("timeout_err_before", timeout_err, 1'b0);
            if (!i_mem_busywait) begin
                got = t;
                break;
            end
        end
        check_eq("timeout_done_cycle", got, TO + 1);
        check_eq("timeout_err_set", timeout_err, 1'b1);
        check_eq("timeout_readdata_kept", i_mem_readdata, m_rdata[1]);
        i_mem_read = 1'b0;
        mem_stall = 1'b0;
        do_trial(1'b1, 1'b1, 1'b0, 6'h05, 6'h12, 32'h0, 2);
        check_eq("timeout_err_sticky", timeout_err, 1'b1);

        // Reset in the third BUSY cycle abandons the access.
        @(negedge clock);
        d_mem_read = 1'b1;
        d_mem_address = 6'h11;
        mem_n = 5;
        $display("txn: d read a=11 interrupted by reset");
        for (int t = 1; t <= 4; t++) begin
            @(negedge clock);
            if (t == 3) begin
                check_eq("strobe_before_reset", mem_read, 1'b1);
                reset = 1'b1;
            end
        end
        check_eq("strobe_after_reset", mem_read, 1'b0);
        check_eq("busywait_after_reset", d_mem_busywait, 1'b1);
        check_eq("timeout_err_cleared", timeout_err, 1'b0);
        check_eq("d_readdata_cleared", d_mem_readdata, '0);
        d_mem_read = 1'b0;
        reset = 1'b0;
        model_reset();
        got = 0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            if (mem_read || mem_write) got++;
        end
        check_eq("no_strobe_after_abort", got, 0);
        // Priority back at D after reset.
        do_trial(1'b1, 1'b1, 1'b0, 6'h05, 6'h30, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
